// File: rtl/fifo_bank_pkg.sv
// Shared definitions for the round-robin FIFO bank.
//   state_e    : arbiter FSM states (IDLE, GRANT)
//   ch_w()     : width of a channel index, never less than 1
//   level_w()  : width of a per-channel fill level (depth 2**aw needs aw+1 bits)
//   DROP_CNT_W : width of the optional per-channel drop counters
package fifo_bank_pkg;

  typedef enum logic {IDLE, GRANT} state_e;

  localparam int unsigned DROP_CNT_W = 16;

  function automatic int unsigned ch_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned level_w(input int unsigned aw);
    return aw + 1;
  endfunction

endpackage

// File: rtl/fifo_bank_rr_sync_fifo.sv
// sync_fifo: single-clock FIFO, depth 2**ADDR_WIDTH, async active-low reset.
// Ports:
//   clk, rst_n     clock / asynchronous active-low reset
//   wr_en, din     write strobe and data; accepted when not full, or when full
//                  and a read happens in the same cycle
//   rd_en          read strobe; caller only asserts it when not empty
//   dout           word at the read pointer (valid while !empty)
//   full, empty    status derived from the registered pointers
//   level          occupancy, derived from the registered pointers
module sync_fifo
  import fifo_bank_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 4
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               wr_en,
  input  logic                               rd_en,
  input  logic [DATA_WIDTH-1:0]              din,
  output logic [DATA_WIDTH-1:0]              dout,
  output logic                               full,
  output logic                               empty,
  output logic [level_w(ADDR_WIDTH)-1:0]     level
);

  logic [ADDR_WIDTH:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH:0]   rd_ptr_q, rd_ptr_d;
  logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];
  logic                  wr_ok;
  logic                  rd_ok;

  // Pointers carry one extra wrap bit: equal -> empty, only MSB differs -> full.
  assign full  = (wr_ptr_q[ADDR_WIDTH] != rd_ptr_q[ADDR_WIDTH]) &&
                 (wr_ptr_q[ADDR_WIDTH-1:0] == rd_ptr_q[ADDR_WIDTH-1:0]);
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign level = wr_ptr_q - rd_ptr_q;
  assign dout  = mem_q[rd_ptr_q[ADDR_WIDTH-1:0]];

  // A read in the same cycle frees the slot, so a write to a full FIFO is kept.
  assign wr_ok = wr_en && (!full || rd_en);
  assign rd_ok = rd_en && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_ok) rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wr_ptr_q[ADDR_WIDTH-1:0]] <= din;
  end

endmodule

// File: rtl/fifo_bank_rr.sv
// fifo_bank_rr: NUM_CH-channel FIFO bank merged onto one valid/ready stream by a
// round-robin burst arbiter (up to BURST_LEN words per grant, one idle cycle
// between grants).
// Ports:
//   clk, rst_n          clock / asynchronous active-low reset
//   in_data, in_valid   per-channel write data/strobe; writes to a full FIFO drop
//   out_data, out_ch    merged output word and its source channel
//   out_valid/out_ready output handshake
//   level               per-channel occupancy
//   ovf, ovf_clr        sticky per-channel overflow flags and their clear
//   drop_cnt            per-channel saturating drop counters (FIFO_STATS_EN only)
// Build option: define FIFO_STATS_EN to add drop_cnt.
module fifo_bank_rr
  import fifo_bank_pkg::*;
#(
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned BURST_LEN  = 188
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic [NUM_CH*DATA_WIDTH-1:0]           in_data,
  input  logic [NUM_CH-1:0]                      in_valid,
  output logic [DATA_WIDTH-1:0]                  out_data,
  output logic [ch_w(NUM_CH)-1:0]                out_ch,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [NUM_CH*level_w(ADDR_WIDTH)-1:0]  level,
  output logic [NUM_CH-1:0]                      ovf,
  input  logic                                   ovf_clr
`ifdef FIFO_STATS_EN
  ,
  output logic [NUM_CH*DROP_CNT_W-1:0]           drop_cnt
`endif
);

  localparam int unsigned CH_W    = ch_w(NUM_CH);
  localparam int unsigned LEVEL_W = level_w(ADDR_WIDTH);
  localparam int unsigned BEAT_W  = $clog2(BURST_LEN + 1);

  logic [DATA_WIDTH-1:0] fifo_dout  [NUM_CH];
  logic [LEVEL_W-1:0]    fifo_level [NUM_CH];
  logic [NUM_CH-1:0]     fifo_full, fifo_empty;
  logic [NUM_CH-1:0]     pop_ch, drop;

  state_e                state_q, state_d;
  logic [CH_W-1:0]       grant_q, grant_d;
  logic [CH_W-1:0]       rr_q, rr_d;
  logic [BEAT_W-1:0]     beat_q, beat_d;
  logic                  pop;
  logic                  pop_en;

  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [CH_W-1:0]       out_ch_q, out_ch_d;
  logic [NUM_CH-1:0]     ovf_q, ovf_d;

  logic                  hi_v, lo_v;
  logic [CH_W-1:0]       hi_ch, lo_ch, pick_ch;

  assign drop = in_valid & fifo_full & ~pop_ch;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    sync_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
    ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .wr_en (in_valid[g]),
      .rd_en (pop_ch[g]),
      .din   (in_data[g*DATA_WIDTH +: DATA_WIDTH]),
      .dout  (fifo_dout[g]),
      .full  (fifo_full[g]),
      .empty (fifo_empty[g]),
      .level (fifo_level[g])
    );
    assign level[g*LEVEL_W +: LEVEL_W] = fifo_level[g];

`ifdef FIFO_STATS_EN
    logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;

    // Clear and increment together leave the count at 1.
    always_comb begin
      drop_cnt_d = drop_cnt_q;
      if (ovf_clr)                          drop_cnt_d = DROP_CNT_W'(drop[g]);
      else if (drop[g] && drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) drop_cnt_q <= '0;
      else        drop_cnt_q <= drop_cnt_d;
    end

    assign drop_cnt[g*DROP_CNT_W +: DROP_CNT_W] = drop_cnt_q;
`endif
  end

  // First non-empty channel at or after rr_q, else the lowest non-empty one (wrap).
  always_comb begin
    hi_v  = 1'b0;
    hi_ch = '0;
    lo_v  = 1'b0;
    lo_ch = '0;
    for (int unsigned c = NUM_CH; c > 0; c--) begin
      if (!fifo_empty[CH_W'(c - 1)]) begin
        lo_v  = 1'b1;
        lo_ch = CH_W'(c - 1);
        if (CH_W'(c - 1) >= rr_q) begin
          hi_v  = 1'b1;
          hi_ch = CH_W'(c - 1);
        end
      end
    end
  end

  assign pick_ch = hi_v ? hi_ch : lo_ch;
  assign pop_en  = !out_valid_q || out_ready;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    rr_d    = rr_q;
    beat_d  = beat_q;
    pop     = 1'b0;
    pop_ch  = '0;
    case (state_q)
      IDLE: begin
        if (lo_v) begin
          grant_d = pick_ch;
          beat_d  = '0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (fifo_empty[grant_q]) begin
          state_d = IDLE;
        end else if (pop_en) begin
          pop             = 1'b1;
          pop_ch[grant_q] = 1'b1;
          beat_d          = beat_q + 1'b1;
          // A same-cycle write to the granted channel keeps it non-empty.
          if (beat_d == BEAT_W'(BURST_LEN) ||
              (fifo_level[grant_q] == LEVEL_W'(1) && !in_valid[grant_q])) begin
            state_d = IDLE;
            rr_d    = (grant_q == CH_W'(NUM_CH - 1)) ? '0 : grant_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    if (pop) begin
      out_valid_d = 1'b1;
      out_data_d  = fifo_dout[grant_q];
      out_ch_d    = grant_q;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Overflow set has priority over the clear.
  assign ovf_d = drop | (ovf_q & ~{NUM_CH{ovf_clr}});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      rr_q        <= '0;
      beat_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      ovf_q       <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      rr_q        <= rr_d;
      beat_q      <= beat_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      ovf_q       <= ovf_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_fifo_bank_rr.sv
module tb_fifo_bank_rr;

  localparam int NUM_CH = 4;
  localparam int DW     = 8;
  localparam int AW     = 4;
  localparam int BL     = 2;
  localparam int LW     = AW + 1;
  localparam int DEPTH  = 16;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [NUM_CH*DW-1:0] in_data = '0;
  logic [NUM_CH-1:0]    in_valid = '0;
  logic [DW-1:0]        out_data;
  logic [1:0]           out_ch;
  logic                 out_valid;
  logic                 out_ready = 1'b0;
  logic [NUM_CH*LW-1:0] level;
  logic [NUM_CH-1:0]    ovf;
  logic                 ovf_clr = 1'b0;
`ifdef FIFO_STATS_EN
  logic [NUM_CH*16-1:0] drop_cnt;
`endif

  int checks = 0;
  int errors = 0;

  fifo_bank_rr #(
    .NUM_CH     (NUM_CH),
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .BURST_LEN  (BL)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .level     (level),
    .ovf       (ovf),
    .ovf_clr   (ovf_clr)
`ifdef FIFO_STATS_EN
    ,
    .drop_cnt  (drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached (checks=%0d errors=%0d)", checks, errors);
    $fatal(1, "watchdog");
  end

  function automatic logic [LW-1:0] lvl(input int ch);
    return level[ch*LW +: LW];
  endfunction

`ifdef FIFO_STATS_EN
  function automatic logic [15:0] dcnt(input int ch);
    return drop_cnt[ch*16 +: 16];
  endfunction
`endif

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = '0;
    in_data  = '0;
    ovf_clr  = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    out_ready = 1'b0;
    rst_n = 1'b0;
    cyc();
    cyc();
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic put(input int ch, input logic [DW-1:0] d);
    in_valid[ch] = 1'b1;
    in_data[ch*DW +: DW] = d;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data: got %h expected 00", out_data); end
    checks++; if (out_ch !== 2'd0) begin errors++; $display("FAIL reset_out_ch: got %0d expected 0", out_ch); end
    checks++; if (level !== '0) begin errors++; $display("FAIL reset_level: got %h expected 0", level); end
    checks++; if (ovf !== '0) begin errors++; $display("FAIL reset_ovf: got %b expected 0", ovf); end
  endtask

  task automatic test_single_word();
    do_reset();
    out_ready = 1'b1;
    put(2, 8'hA5);
    cyc();  // edge k
    idle_inputs();
    checks++; if (lvl(2) !== 5'd1) begin errors++; $display("FAIL single_level_k: got %0d expected 1", lvl(2)); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_valid_k: got %b expected 0", out_valid); end
    cyc();  // k+1
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_valid_k1: got %b expected 0", out_valid); end
    cyc();  // k+2
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid_k2: got %b expected 1", out_valid); end
    checks++; if (out_data !== 8'hA5) begin errors++; $display("FAIL single_data: got %h expected a5", out_data); end
    checks++; if (out_ch !== 2'd2) begin errors++; $display("FAIL single_ch: got %0d expected 2", out_ch); end
    cyc();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_valid_after: got %b expected 0", out_valid); end
    checks++; if (level !== '0) begin errors++; $display("FAIL single_level_after: got %h expected 0", level); end
  endtask

  task automatic test_rr_burst();
    logic [7:0] q [NUM_CH][$];
    logic [7:0] exp_d [$];
    int         exp_c [$];
    int         exp_b [$];
    int         rr, bid, j, last_t;
    do_reset();
    out_ready = 1'b0;
    for (int idx = 0; idx < 3; idx++) begin
      for (int c = 0; c < NUM_CH; c++) begin
        put(c, 8'(c * 16 + idx));
        q[c].push_back(8'(c * 16 + idx));
      end
      cyc();
    end
    idle_inputs();
    // Reference: visit channels round-robin, take up to BL words per visit.
    rr = 0;
    bid = 0;
    while (q[0].size() + q[1].size() + q[2].size() + q[3].size() > 0) begin
      for (int off = 0; off < NUM_CH; off++) begin
        int c;
        c = (rr + off) % NUM_CH;
        if (q[c].size() > 0) begin
          for (int n = 0; n < BL && q[c].size() > 0; n++) begin
            exp_d.push_back(q[c].pop_front());
            exp_c.push_back(c);
            exp_b.push_back(bid);
          end
          bid++;
          rr = (c + 1) % NUM_CH;
          break;
        end
      end
    end
    out_ready = 1'b1;
    j = 0;
    last_t = 0;
    for (int t = 0; t < 100 && j < exp_d.size(); t++) begin
      if (out_valid) begin
        checks++;
        if (out_ch !== 2'(exp_c[j]) || out_data !== exp_d[j]) begin
          errors++;
          $display("FAIL rr_word[%0d]: got ch%0d/%h expected ch%0d/%h", j, out_ch, out_data, exp_c[j], exp_d[j]);
        end
        if (j > 0) begin
          int gap;
          gap = (exp_b[j] == exp_b[j-1]) ? 1 : 2;
          checks++;
          if (t - last_t != gap) begin
            errors++;
            $display("FAIL rr_gap[%0d]: got %0d cycles expected %0d", j, t - last_t, gap);
          end
        end
        last_t = t;
        j++;
      end
      cyc();
    end
    checks++; if (j != 12) begin errors++; $display("FAIL rr_count: got %0d words expected 12", j); end
  endtask

  task automatic test_overflow();
    do_reset();
    out_ready = 1'b0;
    // One word moves to the output register, so 16 + 1 fit before the first drop.
    for (int i = 0; i < DEPTH + 2; i++) begin
      put(1, 8'(i));
      cyc();
    end
    idle_inputs();
    checks++; if (lvl(1) !== 5'd16) begin errors++; $display("FAIL ovf_level: got %0d expected 16", lvl(1)); end
    checks++; if (ovf !== 4'b0010) begin errors++; $display("FAIL ovf_flag: got %b expected 0010", ovf); end
    checks++; if (out_data !== 8'h00 || out_valid !== 1'b1) begin errors++; $display("FAIL ovf_head: got %b/%h expected 1/00", out_valid, out_data); end
`ifdef FIFO_STATS_EN
    checks++; if (dcnt(1) !== 16'd1) begin errors++; $display("FAIL ovf_cnt1: got %0d expected 1", dcnt(1)); end
`endif
    put(1, 8'hF0); cyc();
    put(1, 8'hF1); cyc();
    idle_inputs();
`ifdef FIFO_STATS_EN
    checks++; if (dcnt(1) !== 16'd3) begin errors++; $display("FAIL ovf_cnt3: got %0d expected 3", dcnt(1)); end
`endif
    ovf_clr = 1'b1;
    put(1, 8'hF2);
    cyc();
    idle_inputs();
    checks++; if (ovf !== 4'b0010) begin errors++; $display("FAIL ovf_set_wins: got %b expected 0010", ovf); end
`ifdef FIFO_STATS_EN
    checks++; if (dcnt(1) !== 16'd1) begin errors++; $display("FAIL ovf_cnt_clr_inc: got %0d expected 1", dcnt(1)); end
`endif
    ovf_clr = 1'b1;
    cyc();
    idle_inputs();
    checks++; if (ovf !== 4'b0000) begin errors++; $display("FAIL ovf_clear: got %b expected 0000", ovf); end
    checks++; if (lvl(1) !== 5'd16) begin errors++; $display("FAIL ovf_level_hold: got %0d expected 16", lvl(1)); end
`ifdef FIFO_STATS_EN
    checks++; if (dcnt(1) !== 16'd0) begin errors++; $display("FAIL ovf_cnt_clear: got %0d expected 0", dcnt(1)); end
`endif
  endtask

  task automatic test_full_pop();
    logic [7:0] exp [$];
    int got;
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i <= DEPTH; i++) begin
      put(0, 8'(8'h40 + i));
      cyc();
    end
    idle_inputs();
    checks++; if (lvl(0) !== 5'd16 || ovf !== '0) begin errors++; $display("FAIL full_pre: got level %0d ovf %b expected 16/0000", lvl(0), ovf); end
    checks++; if (out_data !== 8'h40) begin errors++; $display("FAIL full_head: got %h expected 40", out_data); end
    out_ready = 1'b1;
    put(0, 8'hEE);
    cyc();
    idle_inputs();
    out_ready = 1'b0;
    checks++; if (lvl(0) !== 5'd16) begin errors++; $display("FAIL full_pop_level: got %0d expected 16", lvl(0)); end
    checks++; if (ovf[0] !== 1'b0) begin errors++; $display("FAIL full_pop_ovf: got %b expected 0", ovf[0]); end
    checks++; if (out_valid !== 1'b1 || out_data !== 8'h41) begin errors++; $display("FAIL full_pop_next: got %b/%h expected 1/41", out_valid, out_data); end
`ifdef FIFO_STATS_EN
    checks++; if (dcnt(0) !== 16'd0) begin errors++; $display("FAIL full_pop_cnt: got %0d expected 0", dcnt(0)); end
`endif
    for (int i = 1; i <= DEPTH; i++) exp.push_back(8'(8'h40 + i));
    exp.push_back(8'hEE);
    out_ready = 1'b1;
    got = 0;
    for (int t = 0; t < 200 && exp.size() > 0; t++) begin
      if (out_valid) begin
        logic [7:0] e;
        e = exp.pop_front();
        checks++;
        if (out_data !== e || out_ch !== 2'd0) begin
          errors++;
          $display("FAIL full_drain[%0d]: got ch%0d/%h expected ch0/%h", got, out_ch, out_data, e);
        end
        got++;
      end
      cyc();
    end
    checks++; if (got != DEPTH + 1) begin errors++; $display("FAIL full_drain_count: got %0d expected %0d", got, DEPTH + 1); end
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      put(0, 8'(8'h10 + i));
      cyc();
    end
    idle_inputs();
    cyc();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL midrst_pre_valid: got %b expected 1", out_valid); end
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b expected 0", out_valid); end
    checks++; if (level !== '0) begin errors++; $display("FAIL midrst_level: got %h expected 0", level); end
    checks++; if (ovf !== '0) begin errors++; $display("FAIL midrst_ovf: got %b expected 0", ovf); end
    cyc();
    rst_n = 1'b1;
    cyc();
    out_ready = 1'b1;
    put(3, 8'h3C);
    cyc();  // edge k
    idle_inputs();
    cyc();  // k+1
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_k1_valid: got %b expected 0", out_valid); end
    cyc();  // k+2
    checks++; if (out_valid !== 1'b1 || out_data !== 8'h3C || out_ch !== 2'd3) begin
      errors++; $display("FAIL midrst_k2_word: got %b/ch%0d/%h expected 1/ch3/3c", out_valid, out_ch, out_data);
    end
  endtask

  task automatic test_random_backpressure();
    logic [7:0] mq [NUM_CH][$];
    int         written, delivered;
    logic       pv, pr;
    logic [7:0] pd;
    logic [1:0] pc;
    do_reset();
    written = 0;
    delivered = 0;
    pv = 1'b0; pr = 1'b0; pd = '0; pc = '0;
    for (int t = 0; t < 30000 && delivered < 1000; t++) begin
      if (pv && !pr) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== pd || out_ch !== pc) begin
          errors++;
          $display("FAIL rand_stall_stable: got %b/ch%0d/%h expected 1/ch%0d/%h", out_valid, out_ch, out_data, pc, pd);
        end
      end
      out_ready = ($urandom_range(0, 9) < 6);
      if (out_valid && out_ready) begin
        checks++;
        if (mq[out_ch].size() == 0) begin
          errors++;
          $display("FAIL rand_unexpected: got ch%0d/%h expected no word", out_ch, out_data);
        end else begin
          logic [7:0] e;
          e = mq[out_ch].pop_front();
          if (out_data !== e) begin
            errors++;
            $display("FAIL rand_order: ch%0d got %h expected %h", out_ch, out_data, e);
          end
        end
        delivered++;
      end
      // Keep each channel below depth so every write is accepted.
      for (int c = 0; c < NUM_CH; c++) begin
        if (written < 1000 && mq[c].size() < DEPTH - 1 && $urandom_range(0, 2) == 0) begin
          logic [7:0] d;
          d = 8'($urandom);
          put(c, d);
          mq[c].push_back(d);
          written++;
        end else begin
          in_valid[c] = 1'b0;
        end
      end
      pv = out_valid; pr = out_ready; pd = out_data; pc = out_ch;
      cyc();
    end
    idle_inputs();
    checks++; if (delivered != 1000) begin errors++; $display("FAIL rand_delivered: got %0d expected 1000", delivered); end
    checks++; if (ovf !== '0) begin errors++; $display("FAIL rand_ovf: got %b expected 0000", ovf); end
    out_ready = 1'b1;
    cyc();
    cyc();
    checks++; if (level !== '0 || out_valid !== 1'b0) begin errors++; $display("FAIL rand_drained: got level %h valid %b expected 0/0", level, out_valid); end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_rr_burst();
    test_overflow();
    test_full_pop();
    test_reset_mid_burst();
    test_random_backpressure();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
